// File: rtl/matrix_3x3_gen.sv
// matrix_3x3_gen: feeds an external two-line shift RAM and assembles a registered 3x3
// pixel window with top/left border handling. Define MATRIX_BORDER_ZERO_EN for zero borders.
module matrix_3x3_gen #(
  parameter logic [10:0] IMG_HDISP  = 11'd640,
  parameter logic [10:0] IMG_VDISP  = 11'd480,
  parameter int          DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  per_frame_vsync,
  input  logic                  per_frame_href,
  input  logic                  per_frame_clken,
  input  logic [DATA_WIDTH-1:0] per_img_data,
  output logic                  lsr_clken,
  output logic [DATA_WIDTH-1:0] lsr_shiftin,
  input  logic [DATA_WIDTH-1:0] lsr_taps0x,
  input  logic [DATA_WIDTH-1:0] lsr_taps1x,
  output logic                  matrix_frame_vsync,
  output logic                  matrix_frame_href,
  output logic                  matrix_frame_clken,
  output logic [DATA_WIDTH-1:0] matrix_p11,
  output logic [DATA_WIDTH-1:0] matrix_p12,
  output logic [DATA_WIDTH-1:0] matrix_p13,
  output logic [DATA_WIDTH-1:0] matrix_p21,
  output logic [DATA_WIDTH-1:0] matrix_p22,
  output logic [DATA_WIDTH-1:0] matrix_p23,
  output logic [DATA_WIDTH-1:0] matrix_p31,
  output logic [DATA_WIDTH-1:0] matrix_p32,
  output logic [DATA_WIDTH-1:0] matrix_p33
);

  localparam logic [10:0] COL_MAX = IMG_HDISP - 11'd1;

  if (IMG_HDISP < 11'd3 || IMG_VDISP < 11'd3) begin : g_bad_size
    $error("matrix_3x3_gen: image must be at least 3x3");
  end

  logic                  vsync_q, href_q;
  logic                  vsync_rise, href_rise, href_fall;
  logic [1:0]            line_cnt_q, line_cnt_d, line_eff;
  logic                  first_pix_q, first_pix_d, is_first;
  logic [10:0]           col_cnt_q, col_cnt_d, col_base;
  logic [DATA_WIDTH-1:0] row1_q, row2_q, row3_q, row1_d, row2_d, row3_d;
  logic                  s1_first_q, s1_first_d;
  logic                  s1_valid_q;
  logic [1:0]            vsync_dly_q, href_dly_q, clken_dly_q;
  logic [DATA_WIDTH-1:0] p11_q, p12_q, p13_q, p21_q, p22_q, p23_q, p31_q, p32_q, p33_q;
  logic [DATA_WIDTH-1:0] p11_d, p12_d, p13_d, p21_d, p22_d, p23_d, p31_d, p32_d, p33_d;

  assign lsr_clken   = per_frame_clken & per_frame_href;
  assign lsr_shiftin = per_img_data;

  assign vsync_rise = per_frame_vsync & ~vsync_q;
  assign href_rise  = per_frame_href & ~href_q;
  assign href_fall  = ~per_frame_href & href_q;

  // A pixel arriving on the same cycle as the vsync edge already belongs to the new frame.
  assign line_eff = vsync_rise ? 2'd0 : line_cnt_q;
  assign is_first = href_rise | first_pix_q;
  assign col_base = href_rise ? 11'd0 : col_cnt_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    line_cnt_d = line_cnt_q;
    if (vsync_rise) begin
      line_cnt_d = 2'd0;
    end else if (href_fall && line_cnt_q != 2'd2) begin
      line_cnt_d = line_cnt_q + 2'd1;
    end

    first_pix_d = first_pix_q;
    if (lsr_clken) begin
      first_pix_d = 1'b0;
    end else if (href_rise) begin
      first_pix_d = 1'b1;
    end

    col_cnt_d = col_base;
    if (lsr_clken && col_base != COL_MAX) begin
      col_cnt_d = col_base + 11'd1;
    end
  end

  // Stage 1: capture the column and patch rows that lie above the frame.
  always_comb begin
    row1_d     = row1_q;
    row2_d     = row2_q;
    row3_d     = row3_q;
    s1_first_d = s1_first_q;
    if (lsr_clken) begin
      row3_d     = per_img_data;
      row2_d     = lsr_taps0x;
      row1_d     = lsr_taps1x;
      s1_first_d = is_first;
`ifdef MATRIX_BORDER_ZERO_EN
      if (line_eff == 2'd0) row2_d = '0;
      if (line_eff != 2'd2) row1_d = '0;
`else
      if (line_eff == 2'd0) begin
        row2_d = per_img_data;
        row1_d = per_img_data;
      end else if (line_eff == 2'd1) begin
        row1_d = lsr_taps0x;
      end
`endif
    end
  end

  // Stage 2: shift the window left; the first pixel of a line fills the left columns.
  always_comb begin
    {p11_d, p12_d, p13_d} = {p11_q, p12_q, p13_q};
    {p21_d, p22_d, p23_d} = {p21_q, p22_q, p23_q};
    {p31_d, p32_d, p33_d} = {p31_q, p32_q, p33_q};
    if (s1_valid_q) begin
      p13_d = row1_q;
      p23_d = row2_q;
      p33_d = row3_q;
      if (s1_first_q) begin
`ifdef MATRIX_BORDER_ZERO_EN
        {p11_d, p12_d} = '0;
        {p21_d, p22_d} = '0;
        {p31_d, p32_d} = '0;
`else
        {p11_d, p12_d} = {row1_q, row1_q};
        {p21_d, p22_d} = {row2_q, row2_q};
        {p31_d, p32_d} = {row3_q, row3_q};
`endif
      end else begin
        {p11_d, p12_d} = {p12_q, p13_q};
        {p21_d, p22_d} = {p22_q, p23_q};
        {p31_d, p32_d} = {p32_q, p33_q};
      end
    end
  end

  // NOTE: window and pipeline registers are plain flops, so they are reset to give clean zero outputs.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      line_cnt_q  <= 2'd0;
      first_pix_q <= 1'b0;
      col_cnt_q   <= 11'd0;
      row1_q      <= '0;
      row2_q      <= '0;
      row3_q      <= '0;
      s1_first_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      vsync_dly_q <= 2'b00;
      href_dly_q  <= 2'b00;
      clken_dly_q <= 2'b00;
      {p11_q, p12_q, p13_q} <= '0;
      {p21_q, p22_q, p23_q} <= '0;
      {p31_q, p32_q, p33_q} <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      vsync_q     <= per_frame_vsync;
      href_q      <= per_frame_href;
      line_cnt_q  <= line_cnt_d;
      first_pix_q <= first_pix_d;
      col_cnt_q   <= col_cnt_d;
      row1_q      <= row1_d;
      row2_q      <= row2_d;
      row3_q      <= row3_d;
      s1_first_q  <= s1_first_d;
      s1_valid_q  <= lsr_clken;
      vsync_dly_q <= {vsync_dly_q[0], per_frame_vsync};
      href_dly_q  <= {href_dly_q[0], per_frame_href};
      clken_dly_q <= {clken_dly_q[0], per_frame_clken};
      {p11_q, p12_q, p13_q} <= {p11_d, p12_d, p13_d};
      {p21_q, p22_q, p23_q} <= {p21_d, p22_d, p23_d};
      {p31_q, p32_q, p33_q} <= {p31_d, p32_d, p33_d};
    end
  end

  assign matrix_frame_vsync = vsync_dly_q[1];
  assign matrix_frame_href  = href_dly_q[1];
  assign matrix_frame_clken = clken_dly_q[1];

  assign matrix_p11 = p11_q;
  assign matrix_p12 = p12_q;
  assign matrix_p13 = p13_q;
  assign matrix_p21 = p21_q;
  assign matrix_p22 = p22_q;
  assign matrix_p23 = p23_q;
  assign matrix_p31 = p31_q;
  assign matrix_p32 = p32_q;
  assign matrix_p33 = p33_q;

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Testbench for matrix_3x3_gen: random and ramp frames against a window model built from
// the whole frame image with border clamping (or zeroing under MATRIX_BORDER_ZERO_EN).
module tb_matrix_3x3_gen;

  localparam int HD = 5;
  localparam int VD = 5;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       per_frame_vsync = 1'b0, per_frame_href = 1'b0, per_frame_clken = 1'b0;
  logic [7:0] per_img_data = 8'd0, lsr_taps0x = 8'd0, lsr_taps1x = 8'd0;
  logic       lsr_clken;
  logic [7:0] lsr_shiftin;
  logic       matrix_frame_vsync, matrix_frame_href, matrix_frame_clken;
  logic [7:0] matrix_p11, matrix_p12, matrix_p13, matrix_p21, matrix_p22, matrix_p23;
  logic [7:0] matrix_p31, matrix_p32, matrix_p33;

  matrix_3x3_gen #(.IMG_HDISP(11'd5), .IMG_VDISP(11'd5), .DATA_WIDTH(8)) dut (
    .clock(clock), .rst_n(rst_n),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .per_img_data(per_img_data),
    .lsr_clken(lsr_clken), .lsr_shiftin(lsr_shiftin),
    .lsr_taps0x(lsr_taps0x), .lsr_taps1x(lsr_taps1x),
    .matrix_frame_vsync(matrix_frame_vsync), .matrix_frame_href(matrix_frame_href),
    .matrix_frame_clken(matrix_frame_clken),
    .matrix_p11(matrix_p11), .matrix_p12(matrix_p12), .matrix_p13(matrix_p13),
    .matrix_p21(matrix_p21), .matrix_p22(matrix_p22), .matrix_p23(matrix_p23),
    .matrix_p31(matrix_p31), .matrix_p32(matrix_p32), .matrix_p33(matrix_p33)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        v, h, c, upd;
    logic [71:0] win;
    int          l, col;
  } ent_t;

  ent_t        hist[$];
  logic [71:0] cur_win;
  logic [7:0]  img[0:7][0:7];
  logic [71:0] obs_win[0:7][0:7];
  int          n_pass = 0;
  int          n_checks = 0;

  function automatic logic [71:0] dut_win();
    return {matrix_p11, matrix_p12, matrix_p13, matrix_p21, matrix_p22, matrix_p23,
            matrix_p31, matrix_p32, matrix_p33};
  endfunction

  function automatic logic [7:0] pix(int li, int ci);
`ifdef MATRIX_BORDER_ZERO_EN
    if (li < 0 || ci < 0) return 8'd0;
`else
    if (li < 0) li = 0;
    if (ci < 0) ci = 0;
`endif
    return img[li][ci];
  endfunction

  // Window centred one line and one column behind pixel (l,c); row 1 oldest, column 3 newest.
  function automatic logic [71:0] model_win(int l, int c);
    logic [71:0] w = '0;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++)
        w = {w[63:0], pix(l - 2 + r, c - 2 + k)};
    return w;
  endfunction

  task automatic hist_reset();
    ent_t z;
    z.v = 0; z.h = 0; z.c = 0; z.upd = 0; z.win = '0; z.l = -1; z.col = -1;
    hist.delete();
    hist.push_back(z);
    hist.push_back(z);
    cur_win = '0;
  endtask

  // One clock of stimulus; outputs checked at the next negedge against the entry from two clocks ago.
  task automatic step(input logic v, h, c, input logic [7:0] d, t0, t1, input int l, col);
    ent_t e, o;
    per_frame_vsync = v; per_frame_href = h; per_frame_clken = c;
    per_img_data = d; lsr_taps0x = t0; lsr_taps1x = t1;
    e.v = v; e.h = h; e.c = c; e.upd = c & h; e.l = l; e.col = col;
    e.win = (c & h) ? model_win(l, col) : '0;
    hist.push_back(e);
    o = hist.pop_front();
    @(negedge clock);
    if (o.upd) cur_win = o.win;
    n_checks++;
    if ({lsr_clken, lsr_shiftin} !== {c & h, d})
      $display("FAIL lsr_passthru got %b/%h want %b/%h", lsr_clken, lsr_shiftin, c & h, d);
    else n_pass++;
    n_checks++;
    if ({matrix_frame_vsync, matrix_frame_href, matrix_frame_clken} !== {o.v, o.h, o.c})
      $display("FAIL sync_delay got v%b h%b c%b want v%b h%b c%b t=%0t", matrix_frame_vsync,
               matrix_frame_href, matrix_frame_clken, o.v, o.h, o.c, $time);
    else n_pass++;
    n_checks++;
    if (dut_win() !== cur_win)
      $display("FAIL window l%0d c%0d got %h want %h t=%0t", o.l, o.col, dut_win(), cur_win, $time);
    else n_pass++;
    if (o.upd && o.l >= 0 && o.l < 8 && o.col >= 0 && o.col < 8) obs_win[o.l][o.col] = dut_win();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n, input logic v);
    for (int i = 0; i < n; i++) step(v, 0, 0, 8'($urandom), 8'($urandom), 8'($urandom), -1, -1);
  endtask

  // mode 0: clken every cycle, 1: every other cycle, 2: random gaps.
  task automatic run_frame(input int mode, input int width, input bit collide, input int abort_line,
                           input bit ramp);
    for (int l = 0; l < 8; l++)
      for (int c = 0; c < 8; c++)
        img[l][c] = ramp ? 8'(10 * l + c) : 8'($urandom);
    idle(2, 1'b1);
    for (int l = 0; l < VD; l++) begin
      for (int c = 0; c < width; c++) begin
        int  gaps;
        bit  last;
        logic [7:0] t0, t1;
        gaps = (mode == 1) ? ((c > 0) ? 1 : 0) : (mode == 2) ? int'($urandom_range(0, 1)) : 0;
        for (int g = 0; g < gaps; g++)
          step(1, 1, 0, 8'($urandom), 8'($urandom), 8'($urandom), -1, -1);
        last = (l == VD - 1) && (c == width - 1);
        t0 = (l >= 1) ? img[l - 1][c] : 8'($urandom);
        t1 = (l >= 2) ? img[l - 2][c] : 8'($urandom);
        step(!(collide && last), 1, 1, img[l][c], t0, t1, l, c);
        if (l == abort_line && c == 2) begin
          rst_n = 1'b0;
          #1;
          n_checks++;
          if ({matrix_frame_vsync, matrix_frame_href, matrix_frame_clken, dut_win()} !== '0)
            $display("FAIL async_reset got v%b h%b c%b win %h want all 0", matrix_frame_vsync,
                     matrix_frame_href, matrix_frame_clken, dut_win());
          else n_pass++;
          return;
        end
      end
      if (collide && l == VD - 1) return;
      idle(2, 1'b1);
    end
    idle(3, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      per_frame_vsync = 1'($urandom); per_frame_href = 1'($urandom); per_frame_clken = 1'($urandom);
      per_img_data = 8'($urandom); lsr_taps0x = 8'($urandom); lsr_taps1x = 8'($urandom);
      @(negedge clock);
      n_checks++;
      if ({matrix_frame_vsync, matrix_frame_href, matrix_frame_clken, dut_win()} !== '0)
        $display("FAIL reset_state got %h want 0", {matrix_frame_vsync, matrix_frame_href,
                 matrix_frame_clken, dut_win()});
      else n_pass++;
    end
    per_frame_vsync = 0; per_frame_href = 0; per_frame_clken = 0;
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    hist_reset();
    idle(3, 1'b0);
  endtask

  task automatic check_ramp_points(input string tag);
    n_checks++;
    if (obs_win[2][2] !== {8'd0, 8'd1, 8'd2, 8'd10, 8'd11, 8'd12, 8'd20, 8'd21, 8'd22})
      $display("FAIL %s_l2c2 got %h want 0001020a0b0c141516", tag, obs_win[2][2]);
    else n_pass++;
`ifdef MATRIX_BORDER_ZERO_EN
    n_checks++;
    if (obs_win[0][2] !== {48'd0, 8'd0, 8'd1, 8'd2})
      $display("FAIL %s_l0c2 got %h want rows1-2 zero, row3 000102", tag, obs_win[0][2]);
    else n_pass++;
    n_checks++;
    if (obs_win[3][0] !== {16'd0, 8'd10, 16'd0, 8'd20, 16'd0, 8'd30})
      $display("FAIL %s_l3c0 got %h want 00000a00001400001e", tag, obs_win[3][0]);
    else n_pass++;
`else
    n_checks++;
    if (obs_win[0][0] !== 72'd0)
      $display("FAIL %s_l0c0 got %h want 0", tag, obs_win[0][0]);
    else n_pass++;
    n_checks++;
    if (obs_win[1][1] !== {8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd10, 8'd10, 8'd11})
      $display("FAIL %s_l1c1 got %h want 0000010000010a0a0b", tag, obs_win[1][1]);
    else n_pass++;
`endif
  endtask

  task automatic clear_obs();
    for (int l = 0; l < 8; l++)
      for (int c = 0; c < 8; c++) obs_win[l][c] = 'x;
  endtask

  task automatic test_ramp();
    clear_obs();
    run_frame(0, HD, 0, -1, 1);
    check_ramp_points("ramp");
  endtask

  task automatic test_alternate_clken();
    clear_obs();
    run_frame(1, HD, 0, -1, 1);
    check_ramp_points("alt");
  endtask

  task automatic test_random_gaps_excess();
    run_frame(2, HD + 1, 0, -1, 0);
    run_frame(2, HD, 0, -1, 0);
  endtask

  task automatic test_back_to_back_collision();
    run_frame(0, HD, 1, -1, 0);
    run_frame(2, HD, 0, -1, 0);
  endtask

  task automatic test_midline_reset();
    run_frame(0, HD, 0, 3, 0);
    per_frame_vsync = 0; per_frame_href = 0; per_frame_clken = 0;
    @(posedge clock);
    @(posedge clock);
    #1;
    n_checks++;
    if ({matrix_frame_vsync, matrix_frame_href, matrix_frame_clken, dut_win()} !== '0)
      $display("FAIL reset_hold got %h want 0", dut_win());
    else n_pass++;
    rst_n = 1'b1;
    hist_reset();
    idle(2, 1'b0);
    clear_obs();
    run_frame(0, HD, 0, -1, 1);
    check_ramp_points("post_reset");
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_alternate_clken();
    test_random_gaps_excess();
    test_back_to_back_collision();
    test_midline_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/matrix_3x3_gen.md
# matrix_3x3_gen

Consumer-side companion of the two-line shift RAM in the video processing pipeline. It drives an external line shift RAM with the incoming pixel stream and collects the two delayed taps (one and two lines back). From these it builds a registered 3x3 pixel neighbourhood with explicit top/left border handling. The matching frame syncs are delayed to stay aligned. Its outputs feed the Sobel/median/erode style 3x3 operators.

## Interface
Parameters:
- IMG_HDISP, 11'd640, active pixels per line (≥ 3)
- IMG_VDISP, 11'd480, active lines per frame (≥ 3)
- DATA_WIDTH, 8, pixel width

Ports:
- clock  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- per_frame_vsync  in  1  frame sync, high for the whole frame
- per_frame_href  in  1  line valid, high for the whole active line
- per_frame_clken  in  1  pixel strobe, qualifies per_img_data
- per_img_data  in  DATA_WIDTH  current pixel
- lsr_clken  out  1  line RAM shift enable
- lsr_shiftin  out  DATA_WIDTH  line RAM input
- lsr_taps0x  in  DATA_WIDTH  same column, one line earlier
- lsr_taps1x  in  DATA_WIDTH  same column, two lines earlier
- matrix_frame_vsync, matrix_frame_href, matrix_frame_clken  out  1  delayed syncs
- matrix_p11..matrix_p33  out  DATA_WIDTH each  window, pRC with row 1 oldest line and column 3 newest pixel

## Operation
- lsr_clken = per_frame_clken & per_frame_href. lsr_shiftin = per_img_data. Both are combinational pass-throughs.
- Stage 1 (edge with lsr_clken=1): register row3 = per_img_data, row2 = lsr_taps0x, row1 = lsr_taps1x.
- Line counter line_cnt (0..2, saturating):
  - cleared on vsync rising edge;
  - incremented on href falling edge.
- Vertical border substitution at stage 1:
  - line_cnt=0: row1 and row2 are out-of-frame.
  - line_cnt=1: row1 is out-of-frame.
  - Substitute value for out-of-frame rows: see Configuration.
- first_pix flag: set on href rising edge, cleared after the first clken of the line.
- Stage 2 (edge with delayed clken=1): shift the window left by one column. pR1<=pR2, pR2<=pR3, pR3<=stage1 rowR.
- Horizontal border: when the stage-1 pixel is the line's first, pR1 and pR2 load the border value instead of the old columns.
- Column counter col_cnt (0..IMG_HDISP-1) tracks the pixel position in the line.
  - Clears on href rising edge.
  - Excess clken beyond IMG_HDISP in a line are passed through unchanged; col_cnt saturates.
- No state machine beyond the counters and flags. Everything is a fixed 2-stage pipeline.

## Timing
- Latency:
  - per_frame_clken to matrix_frame_clken: exactly 2 clocks.
  - vsync and href are delayed by 2 clocks unconditionally, not clken-gated.
- Output content: a window update is visible on the cycle matrix_frame_clken is high. Matrix outputs hold their value between strobes.
- Back-to-back clken every cycle is supported with no stalls. Gaps in clken are tolerated.
- Simultaneous href falling and vsync rising: vsync wins, so line_cnt=0.
- Reset values: all outputs 0, line_cnt=0, first_pix=0, pipeline registers 0.
- Reset asserted mid-frame:
  - All registers clear immediately.
  - After release, lines are treated as frame top (line_cnt=0) until counting resumes.

## Configuration
- MATRIX_BORDER_ZERO_EN:
  - Defined: out-of-frame rows (top two lines) and out-of-line columns (left of pixel 0) are forced to 0.
  - Undefined (default): edge replication.
    - Top rows copy the nearest valid row: line_cnt=0 gives row1=row2=row3; line_cnt=1 gives row1=row2.
    - Left columns copy column 3 of the first pixel.

## Test plan
- Reset: hold rst_n=0 with random inputs. All outputs are 0; release, then first frame starts at line_cnt=0.
- 5x5 ramp frame (pixel = 10·line+col), clken every cycle, taps modelled by ideal line delay. At line 2 col 2 window = {0,1,2;10,11,12;20,21,22}, appearing exactly 2 clocks after the input strobe.
- Same frame, line 0 col 0, default build: all nine outputs = 0; line 1 col 1 rows {0,1 / 0,1 / 10,11} with left column replicated.
- Same frame with MATRIX_BORDER_ZERO_EN: line 0 col 2 gives rows 1–2 = 0 and row 3 = {0,1,2}; line 3 col 0 gives p11,p12,p21,p22,p31,p32 = 0.
- Clken toggling every other cycle: matrix_frame_clken pattern equals input pattern shifted 2 clocks; windows identical to the continuous case.
- rst_n pulsed low mid-line 3: outputs clear asynchronously. After the next vsync rising edge, line 0 again shows top-border behaviour.
